xif_timer: RTL and testbench

//  Programmable 32-bit timer peripheral on the CPU's external (xif) split bus, beside the LED/switch CSRs.
//  It provides a prescaled up-counter, a compare limit, one-shot/auto-reload modes and a level interrupt to the tile IRQ input.
//  Top-level address decode routes requests in [BASE_ADDR, BASE_ADDR+0x13] here.
//  Its bus_resp_o/bus_rdata_bo are OR-merged with the other xif slaves; rdata is 0 when resp is 0.

---
 rtl/xif_timer.sv | 179 +++++++++++++++++
 tb/tb_xif_timer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/xif_timer.sv
// Programmable 32-bit timer slave on the xif split bus: prescaled up-counter,
// compare limit, one-shot / auto-reload modes and a level interrupt.
module xif_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0010,
    parameter int          PRESC_W   = 16
) (
    input  logic        clk_i,
    input  logic        arst_i,
    input  logic        bus_req_i,
    input  logic        bus_we_i,
    input  logic [31:0] bus_addr_bi,
    input  logic [3:0]  bus_be_bi,
    input  logic [31:0] bus_wdata_bi,
    output logic        bus_ack_o,
    output logic        bus_resp_o,
    output logic [31:0] bus_rdata_bo,
    output logic        irq_o
);

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_LIMIT  = 3'd1;
    localparam logic [2:0] REG_COUNT  = 3'd2;
    localparam logic [2:0] REG_STATUS = 3'd3;
    localparam logic [2:0] REG_PRESC  = 3'd4;
    localparam logic [PRESC_W-1:0] PRESC_ZERO = {PRESC_W{1'b0}};
    localparam logic [PRESC_W-1:0] PRESC_ONE  = {{(PRESC_W-1){1'b0}}, 1'b1};

    function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[b*8 +: 8] = new_val[b*8 +: 8];
            end else begin
                res[b*8 +: 8] = old_val[b*8 +: 8];
            end
        end
        return res;
    endfunction

    logic [31:0]        offset_s;
    logic [2:0]         reg_sel_s;
    logic               hit_s, wr_s, rd_s, tick_s, match_s;
    logic               wr_ctrl_s, wr_limit_s, wr_count_s, wr_status_s, wr_presc_s;

    logic               en_r, auto_r, irq_en_r, pend_r, resp_r;
    logic [31:0]        limit_r, count_r, rdata_r;
    logic [PRESC_W-1:0] presc_r, presc_cnt_r;

    logic               en_s, auto_s, irq_en_s, pend_s;
    logic [31:0]        limit_s, count_s, rdata_s;
    logic [PRESC_W-1:0] presc_s, presc_cnt_s;

    // Addresses below the base wrap to a huge offset and therefore miss.
    assign offset_s  = bus_addr_bi - BASE_ADDR;
    assign hit_s     = (offset_s <= 32'h0000_0010) && (bus_addr_bi[1:0] == 2'b00);
    assign reg_sel_s = offset_s[4:2];
    assign wr_s      = bus_req_i & hit_s & bus_we_i;
    assign rd_s      = bus_req_i & hit_s & ~bus_we_i;
    assign tick_s    = en_r && (presc_cnt_r == presc_r);
    assign match_s   = (count_r == limit_r);

    assign wr_ctrl_s   = wr_s && (reg_sel_s == REG_CTRL);
    assign wr_limit_s  = wr_s && (reg_sel_s == REG_LIMIT);
    assign wr_count_s  = wr_s && (reg_sel_s == REG_COUNT);
    assign wr_status_s = wr_s && (reg_sel_s == REG_STATUS);
    assign wr_presc_s  = wr_s && (reg_sel_s == REG_PRESC);

    // Next-state logic: bus writes take priority over timer updates, except PEND set.
    always_comb begin
        en_s        = en_r;
        auto_s      = auto_r;
        irq_en_s    = irq_en_r;
        pend_s      = pend_r;
        limit_s     = limit_r;
        count_s     = count_r;
        presc_s     = presc_r;
        presc_cnt_s = presc_cnt_r;
        rdata_s     = 32'd0;

        if (!en_r) begin
            presc_cnt_s = PRESC_ZERO;
        end else if (wr_ctrl_s || wr_presc_s || tick_s) begin
            presc_cnt_s = PRESC_ZERO;
        end else begin
            presc_cnt_s = presc_cnt_r + PRESC_ONE;
        end

        if (wr_count_s) begin
            count_s = be_merge(count_r, bus_wdata_bi, bus_be_bi);
        end else if (tick_s && match_s) begin
            count_s = auto_r ? 32'd0 : count_r;
        end else if (tick_s) begin
            count_s = count_r + 32'd1;
        end else begin
            count_s = count_r;
        end

        if (wr_ctrl_s && bus_be_bi[0]) begin
            en_s     = bus_wdata_bi[0];
            auto_s   = bus_wdata_bi[1];
            irq_en_s = bus_wdata_bi[2];
        end else if (tick_s && match_s && !auto_r) begin
            en_s = 1'b0;
        end else begin
            en_s = en_r;
        end

        if (tick_s && match_s) begin
            pend_s = 1'b1;
        end else if (wr_status_s && bus_be_bi[0] && bus_wdata_bi[0]) begin
            pend_s = 1'b0;
        end else begin
            pend_s = pend_r;
        end

        if (wr_limit_s) begin
            limit_s = be_merge(limit_r, bus_wdata_bi, bus_be_bi);
        end else begin
            limit_s = limit_r;
        end

        for (int i = 0; i < PRESC_W; i++) begin
            if (wr_presc_s && bus_be_bi[i/8]) begin
                presc_s[i] = bus_wdata_bi[i];
            end else begin
                presc_s[i] = presc_r[i];
            end
        end

        if (rd_s) begin
            case (reg_sel_s)
                REG_CTRL:   rdata_s = {29'd0, irq_en_r, auto_r, en_r};
                REG_LIMIT:  rdata_s = limit_r;
                REG_COUNT:  rdata_s = count_r;
                REG_STATUS: rdata_s = {31'd0, pend_r};
                REG_PRESC:  rdata_s = 32'(presc_r);
                default:    rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    // State and read-response registers.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            en_r        <= 1'b0;
            auto_r      <= 1'b0;
            irq_en_r    <= 1'b0;
            pend_r      <= 1'b0;
            limit_r     <= 32'd0;
            count_r     <= 32'd0;
            presc_r     <= PRESC_ZERO;
            presc_cnt_r <= PRESC_ZERO;
            resp_r      <= 1'b0;
            rdata_r     <= 32'd0;
        end else begin
            en_r        <= en_s;
            auto_r      <= auto_s;
            irq_en_r    <= irq_en_s;
            pend_r      <= pend_s;
            limit_r     <= limit_s;
            count_r     <= count_s;
            presc_r     <= presc_s;
            presc_cnt_r <= presc_cnt_s;
            resp_r      <= rd_s;
            rdata_r     <= rdata_s;
        end
    end

    assign bus_ack_o    = bus_req_i & hit_s;
    assign bus_resp_o   = resp_r;
    assign bus_rdata_bo = rdata_r;
    assign irq_o        = pend_r & irq_en_r;

endmodule

// File: tb/tb_xif_timer.sv
// Directed bench for xif_timer: read responses are checked by a queue-based
// scoreboard monitor that also verifies the response cycle.
module tb_xif_timer;

    localparam logic [31:0] BASE = 32'h8000_0010;

    logic        clk = 1'b0;
    logic        arst;
    logic        req, we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        ack, resp, irq;
    logic [31:0] rdata;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct {
        int          cyc;
        logic [31:0] off;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    xif_timer #(.BASE_ADDR(BASE), .PRESC_W(16)) dut (
        .clk_i(clk), .arst_i(arst), .bus_req_i(req), .bus_we_i(we),
        .bus_addr_bi(addr), .bus_be_bi(be), .bus_wdata_bi(wdata),
        .bus_ack_o(ack), .bus_resp_o(resp), .bus_rdata_bo(rdata), .irq_o(irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every response must match the head of the queue in data and cycle.
    always @(negedge clk) begin
        exp_t item;
        if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            item = sb.pop_front();
            vectors++;
            if (!resp || sb.size() < 0 || rdata !== item.data || item.cyc != cyc) begin
                miscompares++;
                $display("FAIL rd_off%0h: resp=%b data=%h expected resp=1 data=%h", item.off, resp, rdata, item.data);
            end
        end else if (resp) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_resp: resp=1 data=%h expected no resp", rdata);
        end else if (rdata !== 32'd0) begin
            miscompares++;
            $display("FAIL rdata_idle: got %h expected 00000000", rdata);
        end
    end

    task automatic wr(input logic [31:0] off, input logic [31:0] data, input logic [3:0] bes);
        req = 1'b1; we = 1'b1; addr = BASE + off; be = bes; wdata = data;
        @(posedge clk); #2;
        req = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] off, input logic [31:0] exp);
        req = 1'b1; we = 1'b0; addr = BASE + off; be = 4'h0; wdata = 32'd0;
        #1;
        check("ack", {31'd0, ack}, 32'd1);
        sb.push_back('{cyc: cyc + 1, off: off, data: exp});
        @(posedge clk); #2;
        req = 1'b0;
    endtask

    task automatic rd_raw(input logic [31:0] a, input logic exp_ack);
        req = 1'b1; we = 1'b0; addr = a; be = 4'h0; wdata = 32'd0;
        #1;
        check("ack_decode", {31'd0, ack}, {31'd0, exp_ack});
        @(posedge clk); #2;
        req = 1'b0;
    endtask

    task automatic read_all_zero;
        for (int i = 0; i < 5; i++) rd(32'(i * 4), 32'd0);
    endtask

    initial begin
        logic [31:0] presc_exp [11];
        presc_exp = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2};
        arst = 1'b1; req = 1'b0; we = 1'b0; addr = 32'd0; be = 4'h0; wdata = 32'd0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_resp", {31'd0, resp}, 32'd0);
        arst = 1'b0;

        // 1. reset values
        read_all_zero();
        check("irq_idle", {31'd0, irq}, 32'd0);

        // 2. auto-reload, PRESC=0, LIMIT=3
        wr(32'h10, 32'd0, 4'hF);
        wr(32'h4, 32'd3, 4'hF);
        wr(32'h0, 32'h7, 4'hF);
        rd(32'h8, 32'd0);
        rd(32'h8, 32'd1);
        rd(32'h8, 32'd2);
        check("irq_before_match", {31'd0, irq}, 32'd0);
        rd(32'h8, 32'd3);
        check("irq_at_match", {31'd0, irq}, 32'd1);
        rd(32'h8, 32'd0);
        rd(32'h8, 32'd1);
        wr(32'hC, 32'd1, 4'hF);
        check("irq_cleared", {31'd0, irq}, 32'd0);
        // 5. clear collides with match edge: set wins
        wr(32'hC, 32'd1, 4'hF);
        check("irq_set_wins", {31'd0, irq}, 32'd1);
        rd(32'hC, 32'd1);
        // COUNT write collides with tick: bus value wins
        wr(32'h8, 32'h10, 4'hF);
        rd(32'h8, 32'h10);
        wr(32'h0, 32'd0, 4'hF);
        wr(32'hC, 32'd1, 4'hF);
        rd(32'hC, 32'd0);

        // wrap past LIMIT
        wr(32'h8, 32'hFFFF_FFFF, 4'hF);
        wr(32'h4, 32'd5, 4'hF);
        wr(32'h0, 32'h1, 4'hF);
        rd(32'h8, 32'hFFFF_FFFF);
        rd(32'h8, 32'd0);
        wr(32'h0, 32'd0, 4'hF);

        // 3. prescaler + one-shot
        wr(32'h10, 32'd2, 4'hF);
        wr(32'h4, 32'd2, 4'hF);
        wr(32'h8, 32'd0, 4'hF);
        wr(32'h0, 32'h5, 4'hF);
        for (int i = 0; i < 8; i++) rd(32'h8, presc_exp[i]);
        check("irq_oneshot_pre", {31'd0, irq}, 32'd0);
        for (int i = 8; i < 11; i++) rd(32'h8, presc_exp[i]);
        check("irq_oneshot", {31'd0, irq}, 32'd1);
        rd(32'h0, 32'h4);
        rd(32'hC, 32'd1);
        rd(32'h10, 32'd2);

        // 4. byte enables
        wr(32'h4, 32'd0, 4'hF);
        wr(32'h4, 32'hAABB_CCDD, 4'b0101);
        rd(32'h4, 32'h00BB_00DD);

        // 6. decode misses
        rd_raw(BASE + 32'h14, 1'b0);
        rd_raw(32'h8000_0000, 1'b0);
        rd_raw(BASE + 32'h2, 1'b0);

        // reset the cycle after an accepted read: response dropped
        rd_raw(BASE + 32'h4, 1'b1);
        arst = 1'b1;
        #1;
        check("rst_drop_resp", {31'd0, resp}, 32'd0);
        check("rst_drop_rdata", rdata, 32'd0);
        check("rst_irq2", {31'd0, irq}, 32'd0);
        @(posedge clk); #2;
        arst = 1'b0;
        read_all_zero();

        repeat (3) @(posedge clk);
        #2;
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
